// File: rtl/reg_mux_pkg.sv
// Shared types and constants for the registered CPU register-region multiplexer.
package reg_mux_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } rd_state_t;

  // Returned on a bad channel or a read timeout; sized to DATA_WIDTH at the use site.
  localparam logic [31:0] TIMEOUT_WORD = 32'hDEADBEEF;

endpackage

// File: rtl/reg_mux_wr_slot.sv
// One-entry write slice: holds channel and data until the addressed region takes it.
// Writes to channels >= NUM_RGNS are accepted and silently dropped.
module reg_mux_wr_slot
  import reg_mux_pkg::*;
#(
  parameter int NUM_RGNS   = 4,
  parameter int DATA_WIDTH = 32,
  parameter int CW         = 2
) (
  input  logic                  clk_i,
  input  logic                  rstN_i,
  input  logic                  en_i,
  input  logic [CW-1:0]         chan_i,
  input  logic                  valid_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic                  ready_o,
  output logic [NUM_RGNS-1:0]   muxValid_o,
  output logic [DATA_WIDTH-1:0] muxData_o,
  input  logic [NUM_RGNS-1:0]   muxReady_i
);

  logic                  full_q, full_d;
  logic [CW-1:0]         chan_q, chan_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [NUM_RGNS-1:0]   chanSel;
  logic                  drain;
  logic                  accept;
  logic                  chanOk;

  always_comb begin
    chanSel = '0;
    for (int r = 0; r < NUM_RGNS; r++) begin
      chanSel[r] = (chan_q == CW'(r));
    end
  end

  // A draining slot can be refilled in the same cycle, so ready covers both cases.
  assign drain   = full_q & (|(muxReady_i & chanSel));
  assign ready_o = en_i & (~full_q | drain);
  assign accept  = valid_i & ready_o;
  assign chanOk  = int'(chan_i) < NUM_RGNS;

  always_comb begin
    full_d = full_q;
    chan_d = chan_q;
    data_d = data_q;
    if (accept) begin
      full_d = chanOk;
      if (chanOk) begin
        chan_d = chan_i;
        data_d = data_i;
      end
    end else if (drain) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rstN_i) begin
    if (!rstN_i) begin
      full_q <= 1'b0;
      chan_q <= '0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      chan_q <= chan_d;
      data_q <= data_d;
    end
  end

  assign muxValid_o = {NUM_RGNS{full_q}} & chanSel;
  assign muxData_o  = data_q;

endmodule

// File: rtl/reg_mux_pipe.sv
// Registered CPU register-region multiplexer: buffered write slice plus a read FSM.
// Optional read timeout enabled by defining REG_MUX_TIMEOUT_EN.
module reg_mux_pipe
  import reg_mux_pkg::*;
#(
  parameter int NUM_RGNS       = 4,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 1024,
  localparam int CW            = (NUM_RGNS > 1) ? $clog2(NUM_RGNS) : 1
) (
  input  logic                           clk_in,
  input  logic                           rstN_in,
  input  logic [CW-1:0]                  cpuChan_in,
  input  logic                           cpuWrValid_in,
  input  logic [DATA_WIDTH-1:0]          cpuWrData_in,
  output logic                           cpuWrReady_out,
  input  logic                           cpuRdReqValid_in,
  output logic                           cpuRdReqReady_out,
  output logic [DATA_WIDTH-1:0]          cpuRdData_out,
  output logic                           cpuRdErr_out,
  output logic                           cpuRdValid_out,
  input  logic                           cpuRdReady_in,
  output logic [NUM_RGNS-1:0]            muxWrValid_out,
  output logic [DATA_WIDTH-1:0]          muxWrData_out,
  input  logic [NUM_RGNS-1:0]            muxWrReady_in,
  input  logic [NUM_RGNS*DATA_WIDTH-1:0] muxRdData_in,
  input  logic [NUM_RGNS-1:0]            muxRdValid_in,
  output logic [NUM_RGNS-1:0]            muxRdReady_out
);

  localparam logic [DATA_WIDTH-1:0] TIMEOUT_DATA = DATA_WIDTH'(TIMEOUT_WORD);

  if (NUM_RGNS < 1 || TIMEOUT_CYCLES < 1) begin : gBadParams
    $error("reg_mux_pipe: NUM_RGNS and TIMEOUT_CYCLES must be at least 1");
  end

  rd_state_t             state_q, state_d;
  logic [CW-1:0]         rdChan_q, rdChan_d;
  logic [DATA_WIDTH-1:0] rdData_q, rdData_d;
  logic                  rdErr_q, rdErr_d;
  logic                  rstDone_q;
  logic [NUM_RGNS-1:0]   rdSel;
  logic [DATA_WIDTH-1:0] rdMuxData;
  logic                  rdHit;
  logic                  rdChanOk;
  logic                  tmoHit;

  // Readies stay low until the first clock after reset release, so reset shows all-zero outputs.
  always_ff @(posedge clk_in or negedge rstN_in) begin
    if (!rstN_in) rstDone_q <= 1'b0;
    else          rstDone_q <= 1'b1;
  end

  reg_mux_wr_slot #(
    .NUM_RGNS  (NUM_RGNS),
    .DATA_WIDTH(DATA_WIDTH),
    .CW        (CW)
  ) u_wr_slot (
    .clk_i     (clk_in),
    .rstN_i    (rstN_in),
    .en_i      (rstDone_q),
    .chan_i    (cpuChan_in),
    .valid_i   (cpuWrValid_in),
    .data_i    (cpuWrData_in),
    .ready_o   (cpuWrReady_out),
    .muxValid_o(muxWrValid_out),
    .muxData_o (muxWrData_out),
    .muxReady_i(muxWrReady_in)
  );

  always_comb begin
    rdSel     = '0;
    rdMuxData = '0;
    for (int r = 0; r < NUM_RGNS; r++) begin
      rdSel[r] = (rdChan_q == CW'(r));
      if (rdChan_q == CW'(r)) rdMuxData = muxRdData_in[r*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign rdHit    = |(muxRdValid_in & rdSel);
  assign rdChanOk = int'(cpuChan_in) < NUM_RGNS;

`ifdef REG_MUX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmoCnt_q, tmoCnt_d;

  assign tmoCnt_d = (state_q == WAIT) ? tmoCnt_q + TW'(1) : '0;
  assign tmoHit   = (state_q == WAIT) && (tmoCnt_q == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_in or negedge rstN_in) begin
    if (!rstN_in) tmoCnt_q <= '0;
    else          tmoCnt_q <= tmoCnt_d;
  end
`else
  assign tmoHit = 1'b0;
`endif

  always_comb begin
    state_d           = state_q;
    rdChan_d          = rdChan_q;
    rdData_d          = rdData_q;
    rdErr_d           = rdErr_q;
    cpuRdReqReady_out = 1'b0;
    cpuRdValid_out    = 1'b0;
    muxRdReady_out    = '0;
    unique case (state_q)
      IDLE: begin
        cpuRdReqReady_out = rstDone_q;
        if (cpuRdReqValid_in && rstDone_q) begin
          rdChan_d = cpuChan_in;
          if (rdChanOk) begin
            state_d = WAIT;
          end else begin
            state_d  = RESP;
            rdData_d = TIMEOUT_DATA;
            rdErr_d  = 1'b1;
          end
        end
      end
      WAIT: begin
        muxRdReady_out = rdSel;
        // Region data takes priority over a timeout that expires in the same cycle.
        if (rdHit) begin
          state_d  = RESP;
          rdData_d = rdMuxData;
          rdErr_d  = 1'b0;
        end else if (tmoHit) begin
          state_d  = RESP;
          rdData_d = TIMEOUT_DATA;
          rdErr_d  = 1'b1;
        end
      end
      RESP: begin
        cpuRdValid_out = 1'b1;
        if (cpuRdReady_in) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rstN_in) begin
    if (!rstN_in) begin
      state_q  <= IDLE;
      rdChan_q <= '0;
      rdData_q <= '0;
      rdErr_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      rdChan_q <= rdChan_d;
      rdData_q <= rdData_d;
      rdErr_q  <= rdErr_d;
    end
  end

  assign cpuRdData_out = rdData_q;
  assign cpuRdErr_out  = rdErr_q;

endmodule
